add_tree_seg: RTL and testbench

- Parametrised successor of the fixed 64-input, 16-bit segmented adder tree. It reduces N_IN signed lanes through a registered binary tree and returns segment sums for a runtime-selected segment length.
- Every segment sum, the mode, valid and the bypass vector leave on the same cycle.
- Adds a valid/ready handshake with whole-pipeline stall, bit-growth internal arithmetic, and optional output saturation.
- Sits between the score/exponent stage and the softmax normaliser.

---
 rtl/add_tree_seg.sv | 141 ++++++++++++++
 tb/tb_add_tree_seg.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_tree_seg.sv
// Registered binary adder tree that returns segment sums for a runtime-selected segment length.
// Latency log2(N_IN)+1 cycles (tree stages plus output register); in_ready = out_ready | ~out_valid, whole pipeline stalls together.
module add_tree_seg #(
  parameter int N_IN    = 64,
  parameter int DW      = 16,
  parameter int SEG_MIN = 16,
  parameter bit SAT     = 1'b1,
  localparam int L      = $clog2(N_IN),
  localparam int NSEG   = N_IN / SEG_MIN,
  localparam int MMAX   = $clog2(NSEG),
  localparam int MW     = ($clog2(MMAX + 1) > 1) ? $clog2(MMAX + 1) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MW-1:0]          seg_mode,
  input  logic [N_IN*DW-1:0]     sum_data_flat,
  input  logic [N_IN*DW-1:0]     bypass_flat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MW-1:0]          seg_mode_out,
  output logic [NSEG*DW-1:0]     seg_sum_flat,
  output logic [N_IN*DW-1:0]     bypass_out_flat
);

  localparam int FW = DW + L;
  localparam logic [MW-1:0] MMAX_W = MW'(MMAX);
  localparam logic signed [FW-1:0] SMAX = {{(L + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [FW-1:0] SMIN = {{(L + 1){1'b1}}, {(DW - 1){1'b0}}};

  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Stage k holds N_IN>>k nodes of DW+k bits; stage 0 is the raw input beat.
  for (genvar k = 0; k <= L; k++) begin : stg
    localparam int NN = N_IN >> k;
    localparam int W  = DW + k;
    logic [NN*W-1:0]      flat;
    logic                 vld;
    logic [MW-1:0]        mode;
    logic [N_IN*DW-1:0]   byp;

    if (k == 0) begin : g_in
      assign flat = sum_data_flat;
      assign vld  = in_valid;
      assign mode = seg_mode;
      assign byp  = bypass_flat;
    end else begin : g_reg
      logic [NN*W-1:0] sum_c;
      for (genvar j = 0; j < NN; j++) begin : g_add
        logic signed [W-2:0] a;
        logic signed [W-2:0] b;
        assign a = stg[k-1].flat[(2*j)*(W-1) +: W-1];
        assign b = stg[k-1].flat[(2*j+1)*(W-1) +: W-1];
        assign sum_c[j*W +: W] = W'(a) + W'(b);
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          flat <= '0;
          vld  <= 1'b0;
          mode <= '0;
          byp  <= '0;
        end else if (adv) begin
          flat <= sum_c;
          vld  <= stg[k-1].vld;
          mode <= stg[k-1].mode;
          byp  <= stg[k-1].byp;
        end
      end
    end
  end

  // Per mode m, tap stage L-m and delay it m cycles so it lines up with stage L.
  logic [MMAX:0][NSEG-1:0][FW-1:0] lane_w;

  for (genvar m = 0; m <= MMAX; m++) begin : tap
    localparam int NL = 1 << m;
    localparam int T  = L - m;
    localparam int W  = DW + T;
    logic [NL*W-1:0] aligned;

    if (m == 0) begin : g_direct
      assign aligned = stg[L].flat;
    end else begin : g_dly
      logic [NL*W-1:0] dly [m];
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int d = 0; d < m; d++) dly[d] <= '0;
        end else if (adv) begin
          dly[0] <= stg[T].flat;
          for (int d = 1; d < m; d++) dly[d] <= dly[d-1];
        end
      end
      assign aligned = dly[m-1];
    end

    for (genvar s = 0; s < NSEG; s++) begin : g_lane
      if (s < NL) begin : g_on
        logic signed [W-1:0] v;
        assign v = aligned[s*W +: W];
        assign lane_w[m][s] = FW'(v);
      end else begin : g_off
        assign lane_w[m][s] = '0;
      end
    end
  end

  logic [MW-1:0]        m_c;
  logic signed [FW-1:0] v_c;
  logic [NSEG*DW-1:0]   seg_c;

  always_comb begin
    m_c   = (stg[L].mode > MMAX_W) ? MMAX_W : stg[L].mode;
    v_c   = '0;
    seg_c = '0;
    for (int s = 0; s < NSEG; s++) begin
      v_c = $signed(lane_w[m_c][s]);
      if (SAT && (v_c > SMAX))      seg_c[s*DW +: DW] = SMAX[DW-1:0];
      else if (SAT && (v_c < SMIN)) seg_c[s*DW +: DW] = SMIN[DW-1:0];
      else                          seg_c[s*DW +: DW] = v_c[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid       <= 1'b0;
      seg_mode_out    <= '0;
      seg_sum_flat    <= '0;
      bypass_out_flat <= '0;
    end else if (adv) begin
      out_valid       <= stg[L].vld;
      seg_mode_out    <= stg[L].mode;
      seg_sum_flat    <= seg_c;
      bypass_out_flat <= stg[L].byp;
    end
  end

endmodule

// File: tb/tb_add_tree_seg.sv
// Bench for add_tree_seg: default config, a wrapping (SAT=0) copy and a small N_IN=8 copy.
module tb_add_tree_seg;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [1:0]    seg_mode, mode_out;
  logic [1023:0] sum_data, bypass, byp_out;
  logic [63:0]   seg_sum;

  logic          w_in_ready, w_out_valid;
  logic [1:0]    w_mode_out;
  logic [1023:0] w_byp_out;
  logic [63:0]   w_seg_sum;

  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [1:0]    s_mode, s_mode_out;
  logic [127:0]  s_data, s_byp, s_byp_out;
  logic [63:0]   s_seg_sum;

  add_tree_seg #(.N_IN(64), .DW(16), .SEG_MIN(16), .SAT(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .seg_mode(seg_mode),
    .sum_data_flat(sum_data), .bypass_flat(bypass), .out_valid(out_valid), .out_ready(out_ready),
    .seg_mode_out(mode_out), .seg_sum_flat(seg_sum), .bypass_out_flat(byp_out));

  add_tree_seg #(.N_IN(64), .DW(16), .SEG_MIN(16), .SAT(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .seg_mode(seg_mode),
    .sum_data_flat(sum_data), .bypass_flat(bypass), .out_valid(w_out_valid), .out_ready(out_ready),
    .seg_mode_out(w_mode_out), .seg_sum_flat(w_seg_sum), .bypass_out_flat(w_byp_out));

  add_tree_seg #(.N_IN(8), .DW(16), .SEG_MIN(2), .SAT(1'b1)) dut_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .seg_mode(s_mode),
    .sum_data_flat(s_data), .bypass_flat(s_byp), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .seg_mode_out(s_mode_out), .seg_sum_flat(s_seg_sum), .bypass_out_flat(s_byp_out));

  int checks = 0;
  int failures = 0;

  // Reference: plain sum over each segment, then clamp or wrap to 16 bits.
  function automatic logic [63:0] ref_seg(input logic [1023:0] d, input int mode, input int n,
                                          input int nseg, input bit sat);
    int mmax = $clog2(nseg);
    int m = (mode > mmax) ? mmax : mode;
    int len = n >> m;
    logic [63:0] r = '0;
    longint acc;
    for (int s = 0; s < nseg; s++) begin
      acc = 0;
      if (s < (1 << m))
        for (int i = s * len; i < (s + 1) * len; i++) acc += longint'($signed(d[i*16 +: 16]));
      if (sat) begin
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
      end
      r[s*16 +: 16] = acc[15:0];
    end
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int which, output int cyc);
    cyc = 0;
    while ((((which == 0) ? out_valid : s_out_valid) !== 1'b1) && cyc < 50) begin
      step();
      cyc++;
    end
    if (cyc >= 50) cyc = -1;
  endtask

  task automatic fill_all(input logic [15:0] v);
    for (int i = 0; i < 64; i++) sum_data[i*16 +: 16] = v;
  endtask

  task automatic fill_rand;
    for (int i = 0; i < 64; i++) sum_data[i*16 +: 16] = 16'($urandom);
    for (int i = 0; i < 32; i++) bypass[i*32 +: 32] = $urandom;
  endtask

  task automatic test_reset;
    int cyc;
    logic [1023:0] bp;
    rst = 1'b0;
    repeat (3) step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (seg_sum !== 64'd0) begin failures++; $display("FAIL reset_sum: got %h expected 0", seg_sum); end
    checks++; if (mode_out !== 2'd0 || byp_out !== '0) begin failures++; $display("FAIL reset_mode_byp: got mode %0d byp %h expected 0", mode_out, byp_out); end
    rst = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    fill_all(16'd1);
    for (int i = 0; i < 32; i++) bypass[i*32 +: 32] = $urandom;
    bp = bypass;
    seg_mode = 2'd0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(0, cyc);
    checks++; if (cyc != 6) begin failures++; $display("FAIL latency: got %0d cycles expected 6", cyc); end
    checks++; if (seg_sum !== 64'd64) begin failures++; $display("FAIL ones_sum: got %h expected %h", seg_sum, 64'd64); end
    checks++; if (mode_out !== 2'd0) begin failures++; $display("FAIL ones_mode: got %0d expected 0", mode_out); end
    checks++; if (byp_out !== bp) begin failures++; $display("FAIL ones_bypass: got %h expected %h", byp_out, bp); end
    step();
  endtask

  task automatic test_modes;
    int cyc;
    logic [63:0] exp_s [3];
    logic [1023:0] bp [3];
    exp_s[0] = {16'd0, 16'd0, 16'd0, 16'd2016};
    exp_s[1] = {16'd0, 16'd0, 16'd1520, 16'd496};
    exp_s[2] = {16'd888, 16'd632, 16'd376, 16'd120};
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) sum_data[i*16 +: 16] = 16'(i);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 32; i++) bypass[i*32 +: 32] = $urandom;
      bp[b] = bypass;
      seg_mode = 2'(b);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    wait_out(0, cyc);
    for (int b = 0; b < 3; b++) begin
      checks++; if (out_valid !== 1'b1 || seg_sum !== exp_s[b]) begin failures++; $display("FAIL mode%0d_sum: got v=%b %h expected v=1 %h", b, out_valid, seg_sum, exp_s[b]); end
      checks++; if (mode_out !== 2'(b) || byp_out !== bp[b]) begin failures++; $display("FAIL mode%0d_side: got mode %0d expected %0d", b, mode_out, b); end
      step();
    end
  endtask

  task automatic test_saturation;
    int cyc;
    logic [63:0] exp_s [3];
    logic [63:0] exp_w [3];
    logic [15:0] val [3];
    logic [1:0]  md [3];
    val[0] = 16'h7FFF; md[0] = 2'd2; exp_s[0] = {4{16'h7FFF}};        exp_w[0] = {4{16'hFFF0}};
    val[1] = 16'h8000; md[1] = 2'd0; exp_s[1] = {48'd0, 16'h8000};    exp_w[1] = 64'd0;
    val[2] = 16'h7FFF; md[2] = 2'd0; exp_s[2] = {48'd0, 16'h7FFF};    exp_w[2] = {48'd0, 16'hFFC0};
    out_ready = 1'b1;
    checks++; if (w_in_ready !== 1'b1) begin failures++; $display("FAIL wrap_in_ready: got %b expected 1", w_in_ready); end
    for (int b = 0; b < 3; b++) begin
      fill_all(val[b]);
      seg_mode = md[b];
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    wait_out(0, cyc);
    for (int b = 0; b < 3; b++) begin
      checks++; if (seg_sum !== exp_s[b]) begin failures++; $display("FAIL sat%0d: got %h expected %h", b, seg_sum, exp_s[b]); end
      checks++; if (w_out_valid !== 1'b1 || w_seg_sum !== exp_w[b] || w_mode_out !== md[b]) begin failures++; $display("FAIL wrap%0d: got v=%b %h expected v=1 %h", b, w_out_valid, w_seg_sum, exp_w[b]); end
      step();
    end
  endtask

  task automatic test_backpressure;
    logic [63:0]   q_sum [$];
    logic [1:0]    q_mode [$];
    logic [1023:0] q_byp [$];
    logic [63:0]   p_sum;
    logic [1:0]    p_mode;
    logic [1023:0] p_byp;
    logic stalled = 1'b0;
    int sent = 0;
    int rcvd = 0;
    int cyc = 0;
    while (rcvd < 20 && cyc < 2000) begin
      in_valid = (sent < 20) && ($urandom_range(0, 3) != 0);
      fill_rand();
      seg_mode = 2'($urandom_range(0, 3));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      checks++; if (in_ready !== !(out_valid && !out_ready)) begin failures++; $display("FAIL bp_in_ready: got %b expected %b", in_ready, !(out_valid && !out_ready)); end
      if (stalled) begin
        checks++; if (out_valid !== 1'b1 || seg_sum !== p_sum || mode_out !== p_mode || byp_out !== p_byp) begin failures++; $display("FAIL bp_stable: got v=%b %h expected v=1 %h", out_valid, seg_sum, p_sum); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q_sum.size() == 0) begin
          failures++; $display("FAIL bp_extra_beat: got beat %0d expected none", rcvd);
        end else begin
          if (seg_sum !== q_sum[0] || mode_out !== q_mode[0] || byp_out !== q_byp[0]) begin failures++; $display("FAIL bp_data%0d: got %h mode %0d expected %h mode %0d", rcvd, seg_sum, mode_out, q_sum[0], q_mode[0]); end
          void'(q_sum.pop_front()); void'(q_mode.pop_front()); void'(q_byp.pop_front());
        end
        rcvd++;
      end
      if (in_valid && in_ready) begin
        q_sum.push_back(ref_seg(sum_data, int'(seg_mode), 64, 4, 1'b1));
        q_mode.push_back(seg_mode);
        q_byp.push_back(bypass);
        sent++;
      end
      stalled = out_valid && !out_ready;
      p_sum = seg_sum; p_mode = mode_out; p_byp = byp_out;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (rcvd != 20 || q_sum.size() != 0 || sent != 20) begin failures++; $display("FAIL bp_count: got rcvd %0d sent %0d left %0d expected 20 20 0", rcvd, sent, q_sum.size()); end
    repeat (8) step();
  endtask

  task automatic test_reset_midflight;
    int seen = 0;
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      fill_rand();
      seg_mode = 2'($urandom_range(0, 2));
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++; if (out_valid !== 1'b0 || seg_sum !== 64'd0 || byp_out !== '0 || mode_out !== 2'd0) begin failures++; $display("FAIL midreset_clear: got v=%b %h expected v=0 0", out_valid, seg_sum); end
    repeat (12) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL midreset_ghost: got %0d beats expected 0", seen); end
  endtask

  task automatic test_small;
    int cyc;
    logic [1023:0] d;
    logic [1:0] md [3];
    logic [63:0] e;
    md[0] = 2'd3; md[1] = 2'd0; md[2] = 2'd1;
    s_out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) s_data[i*16 +: 16] = 16'($urandom_range(0, 65535));
      for (int i = 0; i < 4; i++) s_byp[i*32 +: 32] = $urandom;
      d = '0;
      d[127:0] = s_data;
      e = ref_seg(d, int'(md[b]), 8, 4, 1'b1);
      s_mode = md[b];
      checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL small_in_ready%0d: got %b expected 1", b, s_in_ready); end
      s_in_valid = 1'b1;
      step();
      s_in_valid = 1'b0;
      wait_out(1, cyc);
      checks++; if (cyc != 3) begin failures++; $display("FAIL small_latency%0d: got %0d expected 3", b, cyc); end
      checks++; if (s_seg_sum !== e || s_mode_out !== md[b] || s_byp_out !== s_byp) begin failures++; $display("FAIL small_sum%0d: got %h mode %0d expected %h mode %0d", b, s_seg_sum, s_mode_out, e, md[b]); end
      step();
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; seg_mode = 2'd0; sum_data = '0; bypass = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_mode = 2'd0; s_data = '0; s_byp = '0;
    test_reset();
    test_modes();
    test_saturation();
    test_backpressure();
    test_reset_midflight();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish before 500000");
    $fatal(1, "timeout");
  end
endmodule
